// File: rtl/lock_supervisor.sv
// Purpose : supervises the combination-lock FSM: drives the door actuator for a timed window,
//           counts consecutive failures, enforces a timed lockout and re-arms the lock FSM.
// Latency : unlock_in -> door_open 1 cycle; error_in -> fsm_rst 1 cycle; error -> ARMED 2 cycles.
// Backpr. : none; level inputs are sampled only in ARMED (door_closed in OPEN/WAIT_CLOSE).
// Ports   : clk, reset (async, active-high), error_in, unlock_in, door_closed (inputs);
//           fsm_rst, door_open, lockout, alarm, fail_cnt[FAIL_W-1:0] (registered-state outputs).
module lock_supervisor #(
    parameter int MAX_FAIL       = 3,
    parameter int FAIL_W         = 2,
    parameter int OPEN_CYCLES    = 500,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              error_in,
    input  logic              unlock_in,
    input  logic              door_closed,
    output logic              fsm_rst,
    output logic              door_open,
    output logic              lockout,
    output logic              alarm,
    output logic [FAIL_W-1:0] fail_cnt
);

    typedef enum logic [2:0] {
        REARM      = 3'd0,
        ARMED      = 3'd1,
        OPEN       = 3'd2,
        WAIT_CLOSE = 3'd3,
        LOCKOUT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  OPEN_LAST  = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W:0]   FAIL_LIMIT = (FAIL_W + 1)'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_SAT   = FAIL_W'(MAX_FAIL);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  timer_nxt;
    logic [FAIL_W-1:0] fail_nxt;
    logic [FAIL_W:0]   fail_inc;

    // One extra bit so the comparison against MAX_FAIL cannot alias on overflow.
    assign fail_inc = {1'b0, fail_cnt} + (FAIL_W + 1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= REARM;
            timer    <= '0;
            fail_cnt <= '0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            fail_cnt <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt = REARM;
        timer_nxt = '0;
        fail_nxt  = fail_cnt;
        fsm_rst   = 1'b0;
        door_open = 1'b0;
        lockout   = 1'b0;
        alarm     = 1'b0;
        case (state)
            REARM: begin
                fsm_rst   = 1'b1;
                state_nxt = ARMED;
            end
            ARMED: begin
                state_nxt = ARMED;
                // unlock wins over a simultaneous error
                if (unlock_in) begin
                    state_nxt = OPEN;
                    fail_nxt  = '0;
                end else if (error_in && (fail_inc == FAIL_LIMIT)) begin
                    state_nxt = LOCKOUT;
                    fail_nxt  = FAIL_SAT;
                end else if (error_in) begin
                    state_nxt = REARM;
                    fail_nxt  = fail_inc[FAIL_W-1:0];
                end
            end
            OPEN: begin
                door_open = 1'b1;
                if (timer == OPEN_LAST) begin
                    state_nxt = door_closed ? REARM : WAIT_CLOSE;
                end else begin
                    state_nxt = OPEN;
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            WAIT_CLOSE: begin
                alarm = (timer == OPEN_LAST);
                if (door_closed) begin
                    state_nxt = REARM;
                end else begin
                    state_nxt = WAIT_CLOSE;
                    timer_nxt = (timer == OPEN_LAST) ? timer : timer + CNT_W'(1);
                end
            end
            LOCKOUT: begin
                lockout = 1'b1;
                // fsm_rst held throughout, so exit goes straight to ARMED
                fsm_rst = 1'b1;
                if (timer == LOCK_LAST) begin
                    state_nxt = ARMED;
                    fail_nxt  = '0;
                end else begin
                    state_nxt = LOCKOUT;
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = REARM;
            end
        endcase
    end

endmodule

// File: tb/tb_lock_supervisor.sv
// Bench for lock_supervisor: directed scenarios with literal expectations, then randomized
// stimulus compared every cycle against a countdown-style behavioural model.
// Summary printed at the end; every mismatch prints a FAIL line.
module tb_lock_supervisor;

    localparam int MF     = 3;
    localparam int FW     = 2;
    localparam int OC     = 4;
    localparam int LC     = 8;
    localparam int CW     = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          error_in;
    logic          unlock_in;
    logic          door_closed;
    logic          fsm_rst;
    logic          door_open;
    logic          lockout;
    logic          alarm;
    logic [FW-1:0] fail_cnt;

    int total = 0;
    int bad   = 0;

    lock_supervisor #(
        .MAX_FAIL(MF), .FAIL_W(FW), .OPEN_CYCLES(OC), .LOCKOUT_CYCLES(LC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .error_in(error_in), .unlock_in(unlock_in),
        .door_closed(door_closed), .fsm_rst(fsm_rst), .door_open(door_open),
        .lockout(lockout), .alarm(alarm), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: remaining-cycle countdowns ----------------
    bit m_rearm     = 1'b1;
    int m_open_left = 0;
    int m_lock_left = 0;
    bit m_wait      = 1'b0;
    int m_wait_cnt  = 0;
    int m_fails     = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rearm     <= 1'b1;
            m_open_left <= 0;
            m_lock_left <= 0;
            m_wait      <= 1'b0;
            m_wait_cnt  <= 0;
            m_fails     <= 0;
        end else if (m_rearm) begin
            m_rearm <= 1'b0;
        end else if (m_open_left > 0) begin
            m_open_left <= m_open_left - 1;
            if (m_open_left == 1) begin
                if (door_closed) m_rearm <= 1'b1;
                else begin
                    m_wait     <= 1'b1;
                    m_wait_cnt <= 0;
                end
            end
        end else if (m_wait) begin
            if (door_closed) begin
                m_wait  <= 1'b0;
                m_rearm <= 1'b1;
            end else if (m_wait_cnt < OC - 1) begin
                m_wait_cnt <= m_wait_cnt + 1;
            end
        end else if (m_lock_left > 0) begin
            m_lock_left <= m_lock_left - 1;
            if (m_lock_left == 1) m_fails <= 0;
        end else begin
            if (unlock_in) begin
                m_open_left <= OC;
                m_fails     <= 0;
            end else if (error_in) begin
                if (m_fails + 1 == MF) begin
                    m_lock_left <= LC;
                    m_fails     <= MF;
                end else begin
                    m_fails <= m_fails + 1;
                    m_rearm <= 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        chk("model_fsm_rst",   32'(fsm_rst),   32'(m_rearm || (m_lock_left > 0)));
        chk("model_door_open", 32'(door_open), 32'(m_open_left > 0));
        chk("model_lockout",   32'(lockout),   32'(m_lock_left > 0));
        chk("model_alarm",     32'(alarm),     32'(m_wait && (m_wait_cnt == OC - 1)));
        chk("model_fail_cnt",  32'(fail_cnt),  32'(m_fails));
    end

    // ---------------- literal expectations ----------------
    task automatic now_chk(input string nm, input logic f, input logic d, input logic l,
                           input logic a, input logic [FW-1:0] fc);
        chk({nm, "_fsm_rst"},   32'(fsm_rst),   32'(f));
        chk({nm, "_door_open"}, 32'(door_open), 32'(d));
        chk({nm, "_lockout"},   32'(lockout),   32'(l));
        chk({nm, "_alarm"},     32'(alarm),     32'(a));
        chk({nm, "_fail_cnt"},  32'(fail_cnt),  32'(fc));
    endtask

    task automatic cyc(input string nm, input logic f, input logic d, input logic l,
                       input logic a, input logic [FW-1:0] fc);
        @(negedge clk);
        now_chk(nm, f, d, l, a, fc);
    endtask

    task automatic set_in(input logic e, input logic u, input logic dc);
        error_in    = e;
        unlock_in   = u;
        door_closed = dc;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b1);

        // 1: reset and release
        cyc("rst_hold", 1, 0, 0, 0, 0);
        cyc("rst_hold2", 1, 0, 0, 0, 0);
        reset = 1'b0;
        #1 now_chk("rst_rearm", 1, 0, 0, 0, 0);
        cyc("armed0", 0, 0, 0, 0, 0);

        // 2: unlock with door closed -> 4 open cycles, one re-arm cycle
        set_in(1'b0, 1'b1, 1'b1);
        cyc("open_c0", 0, 1, 0, 0, 0);
        set_in(1'b0, 1'b0, 1'b1);
        cyc("open_c1", 0, 1, 0, 0, 0);
        cyc("open_c2", 0, 1, 0, 0, 0);
        cyc("open_c3", 0, 1, 0, 0, 0);
        cyc("open_rearm", 1, 0, 0, 0, 0);
        cyc("open_armed", 0, 0, 0, 0, 0);

        // 3: three failures -> lockout for 8 cycles
        set_in(1'b1, 1'b0, 1'b1);
        cyc("fail1", 1, 0, 0, 0, 1);
        set_in(1'b0, 1'b0, 1'b1);
        cyc("fail1_armed", 0, 0, 0, 0, 1);
        set_in(1'b1, 1'b0, 1'b1);
        cyc("fail2", 1, 0, 0, 0, 2);
        set_in(1'b0, 1'b0, 1'b1);
        cyc("fail2_armed", 0, 0, 0, 0, 2);
        set_in(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < LC; i++) begin
            cyc("lockout_win", 1, 0, 1, 0, 3);
            set_in(1'(i % 2), 1'(i % 3 == 0), 1'b1);
        end
        set_in(1'b0, 1'b0, 1'b1);
        cyc("lockout_exit", 0, 0, 0, 0, 0);

        // 4: unlock with the door never closing -> alarm
        set_in(1'b0, 1'b1, 1'b0);
        cyc("ajar_open0", 0, 1, 0, 0, 0);
        set_in(1'b0, 1'b0, 1'b0);
        cyc("ajar_open1", 0, 1, 0, 0, 0);
        cyc("ajar_open2", 0, 1, 0, 0, 0);
        cyc("ajar_open3", 0, 1, 0, 0, 0);
        cyc("ajar_wait0", 0, 0, 0, 0, 0);
        cyc("ajar_wait1", 0, 0, 0, 0, 0);
        cyc("ajar_wait2", 0, 0, 0, 0, 0);
        cyc("ajar_alarm", 0, 0, 0, 1, 0);
        cyc("ajar_alarm_hold", 0, 0, 0, 1, 0);
        set_in(1'b0, 1'b0, 1'b1);
        cyc("ajar_closed", 1, 0, 0, 0, 0);
        cyc("ajar_armed", 0, 0, 0, 0, 0);

        // 5: error+unlock together at fail_cnt=2 -> open, counter cleared
        set_in(1'b1, 1'b0, 1'b1);
        cyc("both_f1", 1, 0, 0, 0, 1);
        set_in(1'b0, 1'b0, 1'b1);
        cyc("both_a1", 0, 0, 0, 0, 1);
        set_in(1'b1, 1'b0, 1'b1);
        cyc("both_f2", 1, 0, 0, 0, 2);
        set_in(1'b0, 1'b0, 1'b1);
        cyc("both_a2", 0, 0, 0, 0, 2);
        set_in(1'b1, 1'b1, 1'b1);
        cyc("both_open", 0, 1, 0, 0, 0);
        set_in(1'b0, 1'b0, 1'b1);
        repeat (3) cyc("both_open_n", 0, 1, 0, 0, 0);
        cyc("both_rearm", 1, 0, 0, 0, 0);
        cyc("both_armed", 0, 0, 0, 0, 0);

        // 6: async reset in lockout cycle 3
        for (int i = 0; i < MF; i++) begin
            set_in(1'b1, 1'b0, 1'b1);
            @(negedge clk);
            set_in(1'b0, 1'b0, 1'b1);
            if (i < MF - 1) @(negedge clk);
        end
        cyc("lk_c1", 1, 0, 1, 0, 3);
        cyc("lk_c2", 1, 0, 1, 0, 3);
        cyc("lk_c3", 1, 0, 1, 0, 3);
        #2 reset = 1'b1;
        #1 now_chk("async_abort", 1, 0, 0, 0, 0);
        cyc("async_hold", 1, 0, 0, 0, 0);
        reset = 1'b0;
        #1 now_chk("async_rearm", 1, 0, 0, 0, 0);
        cyc("async_armed", 0, 0, 0, 0, 0);

        // randomized phase, checked by the per-cycle model comparison
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            error_in  = ($urandom_range(0, 3) == 0);
            unlock_in = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) door_closed = ~door_closed;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
